// File: rtl/dac_if_pkg.sv
// dac_if_pkg: shared constants for the DAC interface.
//   DW_DEFAULT  default sample width
//   S_*         FSM state encodings
//   midscale()  code the DAC treats as zero, for a given width and format
package dac_if_pkg;

    localparam int unsigned DW_DEFAULT = 12;

    localparam logic [1:0] S_SLEEP = 2'd0;
    localparam logic [1:0] S_PRIME = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    // Zero in the DAC's number format: MSB-only for offset binary, all-zero for two's complement.
    function automatic logic [63:0] midscale(input int unsigned dw, input logic offset_bin);
        return offset_bin ? (64'd1 << (dw - 1)) : 64'd0;
    endfunction

endpackage

// File: rtl/dac_fifo.sv
// dac_fifo: synchronous FIFO with registered full/empty/level and a flush.
//   clk, rst       clock, synchronous active-high reset
//   flush          empties the FIFO (wins over a simultaneous push)
//   push, wr_data  write request and data (ignored when full)
//   pop, rd_data   read request (ignored when empty); rd_data shows the head entry
//   full, empty    registered status
//   level          registered occupancy, 0..DEPTH
module dac_fifo #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;
    logic [LW-1:0]    level_next;

    // Accepted operations and resulting occupancy.
    always_comb begin
        push_ok    = push && !full;
        pop_ok     = pop && !empty;
        level_next = level;
        if (push_ok && !pop_ok) begin
            level_next = level + LW'(1);
        end else if (!push_ok && pop_ok) begin
            level_next = level - LW'(1);
        end
    end

    // Pointers and status; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level_next;
            full  <= (level_next == LW'(DEPTH));
            empty <= (level_next == '0);
        end
    end

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/dac_if.sv
// dac_if: buffers I/Q pairs and serialises them onto an interleaved DAC bus
// at half the clock rate (I word then Q word, WRT strobe on the Q word).
//   clk, rst        clock, synchronous active-high reset
//   EN              run request
//   DATA_I_I/Q      two's complement I and Q samples
//   VALID_I/READY_O pair handshake
//   DAC_D, IQSEL    registered DAC data and I/Q select (1 = I)
//   WRT             registered DAC write strobe
//   SLEEP           DAC power-down
//   UNDERRUN(_CNT)  sticky underrun flag and saturating event count
module dac_if
    import dac_if_pkg::*;
#(
    parameter int unsigned DW          = DW_DEFAULT,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned PRIME_LEVEL = 2,
    parameter int unsigned OFFSET_BIN  = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          EN,
    input  logic [DW-1:0] DATA_I_I,
    input  logic [DW-1:0] DATA_I_Q,
    input  logic          VALID_I,
    output logic          READY_O,
    output logic [DW-1:0] DAC_D,
    output logic          IQSEL,
    output logic          WRT,
    output logic          SLEEP,
    output logic          UNDERRUN,
    output logic [7:0]    UNDERRUN_CNT
);

    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [DW-1:0] MIDSCALE = DW'(midscale(DW, OFFSET_BIN != 0));

    logic [1:0]      state;
    logic [1:0]      state_next;
    logic            phase;
    logic            phase_next;
    logic [DW-1:0]   q_hold;
    logic [DW-1:0]   q_next;
    logic [DW-1:0]   dac_next;
    logic            iqsel_next;
    logic            wrt_next;
    logic            sleep_next;
    logic            underrun_next;
    logic [7:0]      cnt_next;
    logic            underrun_evt;

    logic            push;
    logic            pop;
    logic            flush;
    logic [2*DW-1:0] rd_data;
    logic            full;
    logic            empty;
    logic [LW-1:0]   level;

    // Map a two's complement sample into the DAC's number format.
    function automatic logic [DW-1:0] fmt(input logic [DW-1:0] x);
        return (OFFSET_BIN != 0) ? {~x[DW-1], x[DW-2:0]} : x;
    endfunction

    // full is registered, so a pair is never pushed through a full FIFO.
    assign READY_O = !full && EN && (state != S_SLEEP);
    assign push    = VALID_I && READY_O;
    assign flush   = (state_next == S_SLEEP);

    dac_fifo #(
        .WIDTH (2 * DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .push    (push),
        .wr_data ({DATA_I_I, DATA_I_Q}),
        .pop     (pop),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    // Next-state, pop decision and next output values.
    always_comb begin
        state_next    = state;
        pop           = 1'b0;
        underrun_evt  = 1'b0;
        dac_next      = MIDSCALE;
        iqsel_next    = 1'b1;
        wrt_next      = 1'b0;
        q_next        = q_hold;
        underrun_next = UNDERRUN;
        cnt_next      = UNDERRUN_CNT;

        case (state)
            S_SLEEP: begin
                if (EN) begin
                    state_next = S_PRIME;
                end
            end
            S_PRIME: begin
                if (!phase) begin
                    if (!EN) begin
                        state_next = S_SLEEP;
                    end else if (level >= LW'(PRIME_LEVEL)) begin
                        state_next = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (!EN) begin
                    state_next = S_DRAIN;
                end else if (!phase) begin
                    if (empty) begin
                        underrun_evt = 1'b1;
                        state_next   = S_PRIME;
                    end else begin
                        pop = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (phase) begin
                    state_next = S_SLEEP;
                end
            end
            default: state_next = S_SLEEP;
        endcase

        // Phase sits at 0 in sleep so every active period starts on an I slot.
        phase_next = (state == S_SLEEP || state_next == S_SLEEP) ? 1'b0 : ~phase;
        sleep_next = (state_next == S_SLEEP);

        // A phase-0 edge launches an I word (midscale unless popped);
        // a phase-1 edge launches the held Q word with the strobe.
        // DRAIN only finishes a pair already launched from RUN.
        if (state_next != S_SLEEP && state != S_DRAIN) begin
            if (!phase) begin
                dac_next = pop ? fmt(rd_data[2*DW-1:DW]) : MIDSCALE;
                q_next   = pop ? fmt(rd_data[DW-1:0])    : MIDSCALE;
            end else begin
                dac_next   = q_hold;
                iqsel_next = 1'b0;
                wrt_next   = 1'b1;
            end
        end

        if (state == S_SLEEP && state_next == S_PRIME) begin
            underrun_next = 1'b0;
            cnt_next      = 8'd0;
        end else if (underrun_evt) begin
            underrun_next = 1'b1;
            if (UNDERRUN_CNT != 8'hFF) begin
                cnt_next = UNDERRUN_CNT + 8'd1;
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_SLEEP;
            phase        <= 1'b0;
            q_hold       <= MIDSCALE;
            DAC_D        <= MIDSCALE;
            IQSEL        <= 1'b1;
            WRT          <= 1'b0;
            SLEEP        <= 1'b1;
            UNDERRUN     <= 1'b0;
            UNDERRUN_CNT <= 8'd0;
        end else begin
            state        <= state_next;
            phase        <= phase_next;
            q_hold       <= q_next;
            DAC_D        <= dac_next;
            IQSEL        <= iqsel_next;
            WRT          <= wrt_next;
            SLEEP        <= sleep_next;
            UNDERRUN     <= underrun_next;
            UNDERRUN_CNT <= cnt_next;
        end
    end

endmodule

// File: tb/tb_dac_if.sv
// tb_dac_if: directed bench for dac_if. u_dut uses defaults (offset binary,
// PRIME_LEVEL 2); u_dut2 shares the inputs and uses two's complement with
// PRIME_LEVEL 1.
module tb_dac_if;

    localparam logic [11:0] MID  = 12'h800;
    localparam logic [11:0] MID2 = 12'h000;

    logic        clk;
    logic        rst;
    logic        en;
    logic [11:0] di;
    logic [11:0] dq;
    logic        valid;

    logic        ready,  iqsel,  wrt,  sleep,  underrun;
    logic [11:0] dac_d;
    logic [7:0]  ucnt;
    logic        ready2, iqsel2, wrt2, sleep2, underrun2;
    logic [11:0] dac_d2;
    logic [7:0]  ucnt2;

    int n_vec;
    int n_err;

    dac_if u_dut (
        .clk(clk), .rst(rst), .EN(en), .DATA_I_I(di), .DATA_I_Q(dq), .VALID_I(valid),
        .READY_O(ready), .DAC_D(dac_d), .IQSEL(iqsel), .WRT(wrt), .SLEEP(sleep),
        .UNDERRUN(underrun), .UNDERRUN_CNT(ucnt)
    );

    dac_if #(.OFFSET_BIN(0), .PRIME_LEVEL(1)) u_dut2 (
        .clk(clk), .rst(rst), .EN(en), .DATA_I_I(di), .DATA_I_Q(dq), .VALID_I(valid),
        .READY_O(ready2), .DAC_D(dac_d2), .IQSEL(iqsel2), .WRT(wrt2), .SLEEP(sleep2),
        .UNDERRUN(underrun2), .UNDERRUN_CNT(ucnt2)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; en = 1'b0; valid = 1'b0; di = '0; dq = '0;
        tick; tick;
        rst = 1'b0;
    endtask

    // Reset, enable, push two pairs; returns with the RUN-entry midscale pair
    // already shown, so the next tick shows the first popped I word.
    task automatic start_and_prime(input logic [11:0] i1, input logic [11:0] q1,
                                   input logic [11:0] i2, input logic [11:0] q2);
        do_reset;
        en = 1'b1;
        tick;
        valid = 1'b1; di = i1; dq = q1;
        tick;
        di = i2; dq = q2;
        tick;
        valid = 1'b0;
        tick; tick;
    endtask

    task automatic test_reset;
        do_reset;
        n_vec++;
        if ({dac_d, iqsel, wrt, sleep, ready} !== {MID, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL reset_outputs: got %h want %h", {dac_d, iqsel, wrt, sleep, ready},
                     {MID, 1'b1, 1'b0, 1'b1, 1'b0});
        end
        n_vec++;
        if ({underrun, ucnt} !== 9'd0) begin
            n_err++;
            $display("FAIL reset_underrun: got %b/%0d want 0/0", underrun, ucnt);
        end
        n_vec++;
        if (dac_d2 !== MID2) begin
            n_err++;
            $display("FAIL reset_mid_twos: got %h want %h", dac_d2, MID2);
        end
    endtask

    task automatic test_basic;
        logic [11:0] w [4];
        logic        exp_iq;
        w = '{12'h800, 12'hFFF, 12'h000, 12'h7FF};
        do_reset;
        en = 1'b1;
        tick;
        n_vec++;
        if ({ready, sleep} !== 2'b10) begin
            n_err++;
            $display("FAIL basic_prime_entry: got ready/sleep %b want 10", {ready, sleep});
        end
        valid = 1'b1; di = 12'h000; dq = 12'h7FF;
        tick;
        di = 12'h800; dq = 12'hFFF;
        tick;
        valid = 1'b0;
        n_vec++;
        if ({dac_d, iqsel, wrt} !== {MID, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL basic_prime_strobe: got %h want %h", {dac_d, iqsel, wrt}, {MID, 1'b0, 1'b1});
        end
        tick; tick;
        for (int k = 0; k < 4; k++) begin
            tick;
            exp_iq = (k % 2 == 0);
            n_vec++;
            if ({dac_d, iqsel, wrt} !== {w[k], exp_iq, ~exp_iq}) begin
                n_err++;
                $display("FAIL basic_word%0d: got %h/%b/%b want %h/%b/%b", k, dac_d, iqsel, wrt,
                         w[k], exp_iq, ~exp_iq);
            end
        end
    endtask

    task automatic test_underrun;
        start_and_prime(12'h000, 12'h7FF, 12'h800, 12'hFFF);
        tick; tick; tick; tick;
        n_vec++;
        if (underrun !== 1'b0) begin
            n_err++;
            $display("FAIL underrun_early: got %b want 0", underrun);
        end
        tick;
        n_vec++;
        if ({dac_d, iqsel, wrt, underrun, ucnt} !== {MID, 1'b1, 1'b0, 1'b1, 8'd1}) begin
            n_err++;
            $display("FAIL underrun_event: got %h/%b/%b/%b/%0d want 800/1/0/1/1",
                     dac_d, iqsel, wrt, underrun, ucnt);
        end
        tick;
        n_vec++;
        if ({dac_d, iqsel, wrt} !== {MID, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL underrun_strobe: got %h/%b/%b want 800/0/1", dac_d, iqsel, wrt);
        end
        tick; tick; tick; tick;
        n_vec++;
        if ({dac_d, ucnt, underrun, sleep} !== {MID, 8'd1, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL underrun_back_to_prime: got dac %h cnt %0d flag %b sleep %b want 800 1 1 0",
                     dac_d, ucnt, underrun, sleep);
        end
    endtask

    task automatic test_full;
        logic [11:0] pi [5];
        logic [11:0] pq [5];
        logic [11:0] w  [8];
        pi = '{12'h111, 12'h333, 12'h555, 12'h777, 12'h0CD};
        pq = '{12'h222, 12'h444, 12'h666, 12'h0AB, 12'h0EF};
        w  = '{12'h911, 12'hA22, 12'hB33, 12'hC44, 12'hD55, 12'hE66, 12'hF77, 12'h8AB};
        do_reset;
        en = 1'b1;
        tick;
        valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if (ready !== 1'b1) begin
                n_err++;
                $display("FAIL full_ready_before%0d: got %b want 1", k, ready);
            end
            di = pi[k]; dq = pq[k];
            tick;
        end
        di = pi[4]; dq = pq[4];
        n_vec++;
        if (ready !== 1'b0) begin
            n_err++;
            $display("FAIL full_ready_low: got %b want 0", ready);
        end
        tick;
        valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) tick;
            n_vec++;
            if (dac_d !== w[k]) begin
                n_err++;
                $display("FAIL full_word%0d: got %h want %h", k, dac_d, w[k]);
            end
        end
        tick;
        n_vec++;
        if ({dac_d, underrun} !== {MID, 1'b1}) begin
            n_err++;
            $display("FAIL full_no_extra: got %h/%b want 800/1", dac_d, underrun);
        end
    endtask

    task automatic test_drain;
        start_and_prime(12'h000, 12'h7FF, 12'h800, 12'hFFF);
        tick;
        en = 1'b0;
        tick;
        n_vec++;
        if ({dac_d, iqsel, wrt, sleep} !== {12'hFFF, 1'b0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL drain_q_word: got %h/%b/%b/%b want fff/0/1/0", dac_d, iqsel, wrt, sleep);
        end
        tick;
        n_vec++;
        if ({dac_d, iqsel, wrt, sleep} !== {MID, 1'b1, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL drain_tail: got %h/%b/%b/%b want 800/1/0/0", dac_d, iqsel, wrt, sleep);
        end
        tick;
        n_vec++;
        if ({dac_d, iqsel, wrt, sleep} !== {MID, 1'b1, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL drain_sleep: got %h/%b/%b/%b want 800/1/0/1", dac_d, iqsel, wrt, sleep);
        end
        // A leftover pair would be popped ahead of the new ones.
        en = 1'b1;
        tick;
        valid = 1'b1; di = 12'h100; dq = 12'h200;
        tick;
        di = 12'h300; dq = 12'h400;
        tick;
        valid = 1'b0;
        tick; tick; tick;
        n_vec++;
        if ({dac_d, iqsel} !== {12'h900, 1'b1}) begin
            n_err++;
            $display("FAIL drain_flushed_i: got %h/%b want 900/1", dac_d, iqsel);
        end
        tick;
        n_vec++;
        if ({dac_d, iqsel, wrt} !== {12'hA00, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL drain_flushed_q: got %h/%b/%b want a00/0/1", dac_d, iqsel, wrt);
        end
        en = 1'b0;
        tick; tick; tick; tick;
    endtask

    task automatic test_mid_reset;
        start_and_prime(12'h000, 12'h7FF, 12'h800, 12'hFFF);
        tick; tick;
        n_vec++;
        if (wrt !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_in_q: got wrt %b want 1", wrt);
        end
        rst = 1'b1;
        tick;
        n_vec++;
        if ({dac_d, iqsel, wrt, sleep, ready, underrun, ucnt} !==
            {MID, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0}) begin
            n_err++;
            $display("FAIL midrst_outputs: got %h/%b/%b/%b/%b/%b/%0d want 800/1/0/1/0/0/0",
                     dac_d, iqsel, wrt, sleep, ready, underrun, ucnt);
        end
        rst = 1'b0;
        tick;
        n_vec++;
        if ({dac_d, iqsel, wrt} !== {MID, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL midrst_no_partial: got %h/%b/%b want 800/1/0", dac_d, iqsel, wrt);
        end
    endtask

    task automatic test_twos;
        logic [11:0] w2 [4];
        logic [11:0] w1 [4];
        w2 = '{12'h800, 12'h001, 12'h123, 12'h456};
        w1 = '{12'h000, 12'h801, 12'h923, 12'hC56};
        start_and_prime(12'h800, 12'h001, 12'h123, 12'h456);
        n_vec++;
        if ({dac_d2, iqsel2, wrt2} !== {MID2, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL twos_midscale: got %h/%b/%b want 000/0/1", dac_d2, iqsel2, wrt2);
        end
        for (int k = 0; k < 4; k++) begin
            tick;
            n_vec++;
            if ({dac_d2, dac_d} !== {w2[k], w1[k]}) begin
                n_err++;
                $display("FAIL twos_word%0d: got %h/%h want %h/%h", k, dac_d2, dac_d, w2[k], w1[k]);
            end
        end
    endtask

    // u_dut2 (PRIME_LEVEL 1) sees exactly one underrun per 8-cycle push period.
    task automatic test_saturate;
        do_reset;
        en = 1'b1;
        tick;
        for (int n = 0; n < 300; n++) begin
            valid = 1'b1; di = 12'h042; dq = 12'h024;
            tick;
            valid = 1'b0;
            repeat (7) tick;
            if (n == 99) begin
                n_vec++;
                if ({underrun2, ucnt2} !== {1'b1, 8'd100}) begin
                    n_err++;
                    $display("FAIL sat_count100: got %b/%0d want 1/100", underrun2, ucnt2);
                end
            end
        end
        n_vec++;
        if (ucnt2 !== 8'd255) begin
            n_err++;
            $display("FAIL sat_count255: got %0d want 255", ucnt2);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        clk = 1'b0; rst = 1'b1; en = 1'b0; valid = 1'b0; di = '0; dq = '0;
        n_vec = 0; n_err = 0;
        test_reset;
        test_basic;
        test_underrun;
        test_full;
        test_drain;
        test_mid_reset;
        test_twos;
        test_saturate;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
